bcd_updown_counter: RTL and testbench

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

---
 rtl/bcd_updown_counter.sv | 121 ++++++++++++
 tb/tb_bcd_updown_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Up/down packed-BCD counter with modulus, parallel load, sticky overflow and cascade tc.
// Define BCD_CNT_SAT_EN to saturate at the count limits instead of wrapping.
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int MODULO = 100
) (
  input  logic                clk_div,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  input  logic                clr_ovf,
  output logic [4*DIGITS-1:0] dout,
  output logic                tc,
  output logic                ovf,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] res;
    int r;
    res = '0;
    r   = v;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return res;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         borrow;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // With valid digits, packed BCD orders the same as its decimal value.
  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULO - 1);

  logic           at_max;
  logic           at_zero;
  logic           load_ok;
  logic [W-1:0]   next_count;

  always_comb begin
    at_max  = (dout == MAX_BCD);
    at_zero = (dout == '0);
    tc      = en & ~load & ((up & at_max) | (~up & at_zero));
    load_ok = bcd_valid(din) && (din <= MAX_BCD);
`ifdef BCD_CNT_SAT_EN
    if (tc)
      next_count = dout;
    else
      next_count = up ? bcd_inc(dout) : bcd_dec(dout);
`else
    if (up)
      next_count = at_max ? '0 : bcd_inc(dout);
    else
      next_count = at_zero ? MAX_BCD : bcd_dec(dout);
`endif
  end

  // tc marks exactly the edges that wrap (or saturate), so it also drives ovf.
  always_ff @(posedge clk_div) begin
    if (rst) begin
      dout     <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= load & ~load_ok;
      if (load) begin
        if (load_ok) dout <= din;
      end else if (en) begin
        dout <= next_count;
      end
      ovf <= tc | (ovf & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter across four parameterisations sharing one stimulus bus.
module tb_bcd_updown_counter;

  logic        clk_div = 1'b0;
  logic        rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0, clr_ovf = 1'b0;
  logic [11:0] din = '0;

  logic [7:0]  dout_a, dout_b;
  logic [3:0]  dout_c;
  logic [11:0] dout_d;
  logic        tc_a, tc_b, tc_c, tc_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;
  logic        lerr_a, lerr_b, lerr_c, lerr_d;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          sel;
    logic        chk;
    logic [11:0] dout;
    logic        ovf;
    logic        lerr;
    string       nm;
  } exp_t;

  exp_t sb[$];

  always #5 clk_div = ~clk_div;

  bcd_updown_counter #(.DIGITS(2), .MODULO(100)) u_a (
    .clk_div(clk_div), .rst(rst), .en(en), .up(up), .load(load), .din(din[7:0]),
    .clr_ovf(clr_ovf), .dout(dout_a), .tc(tc_a), .ovf(ovf_a), .load_err(lerr_a));
  bcd_updown_counter #(.DIGITS(2), .MODULO(60)) u_b (
    .clk_div(clk_div), .rst(rst), .en(en), .up(up), .load(load), .din(din[7:0]),
    .clr_ovf(clr_ovf), .dout(dout_b), .tc(tc_b), .ovf(ovf_b), .load_err(lerr_b));
  bcd_updown_counter #(.DIGITS(1), .MODULO(10)) u_c (
    .clk_div(clk_div), .rst(rst), .en(en), .up(up), .load(load), .din(din[3:0]),
    .clr_ovf(clr_ovf), .dout(dout_c), .tc(tc_c), .ovf(ovf_c), .load_err(lerr_c));
  bcd_updown_counter #(.DIGITS(3), .MODULO(1000)) u_d (
    .clk_div(clk_div), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .clr_ovf(clr_ovf), .dout(dout_d), .tc(tc_d), .ovf(ovf_d), .load_err(lerr_d));

  function automatic logic [11:0] get_dout(input int s);
    case (s)
      0: return {4'h0, dout_a};
      1: return {4'h0, dout_b};
      2: return {8'h00, dout_c};
      default: return dout_d;
    endcase
  endfunction

  function automatic logic get_tc(input int s);
    case (s)
      0: return tc_a;
      1: return tc_b;
      2: return tc_c;
      default: return tc_d;
    endcase
  endfunction

  function automatic logic get_ovf(input int s);
    case (s)
      0: return ovf_a;
      1: return ovf_b;
      2: return ovf_c;
      default: return ovf_d;
    endcase
  endfunction

  function automatic logic get_lerr(input int s);
    case (s)
      0: return lerr_a;
      1: return lerr_b;
      2: return lerr_c;
      default: return lerr_d;
    endcase
  endfunction

  // Drive one cycle of stimulus, check tc before the edge, queue the post-edge expectation.
  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [11:0] d, input logic c, input int s,
                      input logic chk, input logic [11:0] ed, input logic eo, input logic el,
                      input logic tchk, input logic etc, input string nm);
    exp_t it;
    @(negedge clk_div);
    rst = r; en = e; up = u; load = l; din = d; clr_ovf = c;
    #1;
    if (tchk) begin
      checks++;
      if (get_tc(s) !== etc) begin
        failures++;
        $display("FAIL %s tc: got %0b expected %0b", nm, get_tc(s), etc);
      end
    end
    it.sel = s; it.chk = chk; it.dout = ed; it.ovf = eo; it.lerr = el; it.nm = nm;
    sb.push_back(it);
  endtask

  function automatic logic [11:0] dec2bcd(input int n);
    return 12'(((n / 100) << 8) | (((n / 10) % 10) << 4) | (n % 10));
  endfunction

  initial begin : monitor
    exp_t it;
    forever begin
      @(posedge clk_div);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        if (it.chk) begin
          checks++;
          if (get_dout(it.sel) !== it.dout) begin
            failures++;
            $display("FAIL %s dout: got %h expected %h", it.nm, get_dout(it.sel), it.dout);
          end
          checks++;
          if (get_ovf(it.sel) !== it.ovf) begin
            failures++;
            $display("FAIL %s ovf: got %0b expected %0b", it.nm, get_ovf(it.sel), it.ovf);
          end
          checks++;
          if (get_lerr(it.sel) !== it.lerr) begin
            failures++;
            $display("FAIL %s load_err: got %0b expected %0b", it.nm, get_lerr(it.sel), it.lerr);
          end
        end
      end
    end
  end

  initial begin : stim
    int waited;
    //   r  e  u  l  din     c  sel chk exp_dout exp_ovf exp_lerr tchk etc  name
    step(1, 0, 0, 0, 12'h0,  0, 0, 1, 12'h00, 0, 0, 0, 0, "reset_a");
    step(1, 1, 0, 0, 12'h0,  0, 0, 1, 12'h00, 0, 0, 1, 1, "rst_hold_tc");
    // Full up-count cycle through 99 and the wrap back to 00.
    for (int i = 0; i < 100; i++)
      step(0, 1, 1, 0, 12'h0, 0, 0, 1, dec2bcd((i + 1) % 100), (i == 99), 0,
           1, (i == 99), "count_up");
    step(0, 0, 1, 0, 12'h0,  0, 0, 1, 12'h00, 1, 0, 1, 0, "idle_hold");
    step(0, 0, 1, 0, 12'h0,  1, 0, 1, 12'h00, 0, 0, 0, 0, "clr_ovf");
    step(0, 0, 1, 1, 12'h37, 0, 0, 1, 12'h37, 0, 0, 0, 0, "load_37");
    step(1, 1, 1, 1, 12'h37, 0, 0, 1, 12'h00, 0, 0, 0, 0, "rst_over_load");
    step(0, 0, 1, 1, 12'h99, 0, 0, 1, 12'h99, 0, 0, 0, 0, "load_99");
    step(0, 1, 1, 0, 12'h0,  0, 0, 1, 12'h00, 1, 0, 1, 1, "wrap_up");
    step(0, 1, 0, 0, 12'h0,  1, 0, 1, 12'h99, 1, 0, 1, 1, "wrap_beats_clr");
    step(0, 1, 1, 1, 12'h9A, 0, 0, 1, 12'h99, 1, 1, 1, 0, "bad_digit");
    step(0, 0, 1, 0, 12'h0,  0, 0, 1, 12'h99, 1, 0, 0, 0, "lerr_pulse_end");

    step(1, 0, 0, 0, 12'h0,  0, 1, 1, 12'h00, 0, 0, 0, 0, "reset_b");
    step(0, 0, 0, 1, 12'h59, 0, 1, 1, 12'h59, 0, 0, 0, 0, "m60_load59");
    step(0, 1, 0, 0, 12'h0,  0, 1, 1, 12'h58, 0, 0, 1, 0, "m60_down");
    step(0, 1, 1, 0, 12'h0,  0, 1, 1, 12'h59, 0, 0, 1, 0, "m60_up");
    step(0, 1, 1, 0, 12'h0,  0, 1, 1, 12'h00, 1, 0, 1, 1, "m60_wrap");
    step(0, 1, 0, 1, 12'h60, 0, 1, 1, 12'h00, 1, 1, 1, 0, "m60_reject60");
    step(0, 0, 0, 0, 12'h0,  0, 1, 1, 12'h00, 1, 0, 0, 0, "m60_lerr_end");

    step(1, 0, 0, 0, 12'h0,  0, 2, 1, 12'h0,  0, 0, 0, 0, "reset_c");
    step(0, 1, 0, 0, 12'h0,  0, 2, 1, 12'h9,  1, 0, 1, 1, "m10_wrap_down");
    step(0, 0, 0, 0, 12'h0,  1, 2, 1, 12'h9,  0, 0, 1, 0, "m10_clr");
    step(0, 1, 1, 0, 12'h0,  0, 2, 1, 12'h0,  1, 0, 1, 1, "m10_wrap_up");

    step(1, 0, 0, 0, 12'h0,   0, 3, 1, 12'h000, 0, 0, 0, 0, "reset_d");
    step(0, 1, 1, 1, 12'h123, 0, 3, 1, 12'h123, 0, 0, 1, 0, "d3_load_en");
    step(0, 1, 1, 1, 12'h1A3, 0, 3, 1, 12'h123, 0, 1, 1, 0, "d3_bad_digit");
    step(0, 1, 0, 0, 12'h0,   0, 3, 1, 12'h122, 0, 0, 1, 0, "d3_down");
    step(0, 0, 0, 0, 12'h0,   0, 3, 1, 12'h122, 0, 0, 0, 0, "d3_idle");

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge clk_div);
      waited++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
